count_down_timer: RTL and testbench
===================================

Name: count_down_timer

Overview:
- Loadable, enable-gated down-counter: the counterpart of the up-counting enable counter in the counter library.
- Loads a start value, decrements on each enabled clock and flags terminal count at zero.
- Holds a done flag until the consumer acknowledges it.
- Used as a programmable delay/timeout timer for controllers in the sequential-logic library.

Parameters:
- WIDTH, 8, bit width of load value and count; maximum load 2^WIDTH-1.

Ports:
- iClock  input  1  rising-edge clock.
- iReset  input  1  asynchronous, active-low reset.
- iStart  input  1  load iLoadVal and start counting; sampled on rising edge.
- iLoadVal  input  WIDTH  start value captured when iStart accepted.
- iEnable  input  1  count-enable; decrement only when 1 in RUN.
- iAck  input  1  consumer acknowledge; clears oDone.
- oCount  output  WIDTH  current count value.
- oBusy  output  1  1 while in RUN.
- oDone  output  1  1 from terminal count until acknowledged.
- oTc  output  1  one-cycle pulse on the cycle oCount becomes 0 by decrement or zero load.

Behaviour:
- Reset (iReset=0, asynchronous):
  - state=IDLE, oCount=0, oBusy=0, oDone=0, oTc=0, period register=0.
  - Reset takes effect immediately, including mid-count; no pulse is generated.
- States: IDLE, RUN, DONE. oBusy=1 only in RUN. oDone=1 only in DONE, except under the optional feature.
- IDLE:
  - iStart=1 and iLoadVal!=0 -> oCount<=iLoadVal, period<=iLoadVal, go RUN.
  - iStart=1 and iLoadVal==0 -> oCount<=0, oTc=1 next cycle, go DONE.
  - Otherwise hold. iEnable and iAck are ignored.
- RUN:
  - iStart=1 has highest priority: reload from iLoadVal (zero-load rule as in IDLE) and restart. No oTc for the abandoned count.
  - Else iEnable=1 and oCount>1 -> oCount<=oCount-1.
  - Else iEnable=1 and oCount==1 -> oCount<=0, oTc pulses in the cycle oCount reads 0, go DONE.
  - iEnable=0 -> hold value and state (pause).
- DONE:
  - oCount holds 0.
  - iStart=1 takes priority over iAck: reload per IDLE rules.
  - Else iAck=1 -> go IDLE; oDone falls next cycle.
  - iEnable is ignored.
- Latency:
  - Load value visible on oCount one cycle after the iStart edge.
  - A load of N with iEnable held high reaches 0 exactly N enabled cycles after entering RUN.
- Arithmetic: unsigned, WIDTH-bit. Never decrements below 0; no wrap from 0 to 2^WIDTH-1 in any state.
- oTc is registered and high exactly one cycle per terminal event.
- iAck in IDLE or RUN has no effect.

Optional Feature:
- Macro: COUNT_DOWN_TIMER_AUTO_RELOAD_EN.
- Defined (periodic mode):
  - In RUN, when oCount would reach 0, oCount reloads from the period register instead; state stays RUN.
  - oTc pulses for one cycle on each reload.
  - oDone is set (sticky) on each reload and cleared by iAck while counting continues.
  - A zero load still goes to DONE as without the feature.
  - Period N gives one oTc every N enabled cycles.
- Undefined: one-shot behaviour as specified above; no period register is required beyond the load capture.

Test Plan:
- Reset mid-count: load 10, count 3 cycles, drive iReset=0 asynchronously -> oCount=0, oBusy=0, oDone=0, oTc=0 immediately, with no clock edge needed.
- One-shot: WIDTH=8, iStart with iLoadVal=5, iEnable=1 -> oCount 5,4,3,2,1,0; oTc high one cycle at 0; oDone held until iAck; IDLE the cycle after iAck.
- Pause: load 4, iEnable toggled 1,0,0,1,1,1 -> oCount 4,3,3,3,2,1,0; oTc only at 0.
- Restart and zero load: load 6, after 2 decrements iStart with iLoadVal=9 -> oCount=9, no oTc. Separately, load 0 -> DONE next cycle with oTc=1, oCount=0.
- Boundaries: load 255 with iEnable=1 -> exactly 255 enabled cycles to 0, no underflow. In DONE, iStart and iAck asserted together -> reload wins, state RUN.
- With COUNT_DOWN_TIMER_AUTO_RELOAD_EN: load 3, iEnable=1 for 9 cycles -> oTc pulses every 3rd cycle, oBusy stays 1. oDone sticky after the first reload; iAck clears it without stopping the count.

Source files
------------

// File: rtl/count_down_timer_if.sv
// Bus bundle for count_down_timer: control inputs toward the timer and
// count/status outputs back to the consumer.
interface count_down_timer_if #(
  parameter int WIDTH = 8
);
  logic             iStart;
  logic [WIDTH-1:0] iLoadVal;
  logic             iEnable;
  logic             iAck;
  logic [WIDTH-1:0] oCount;
  logic             oBusy;
  logic             oDone;
  logic             oTc;

  // Controller side: drives start/load/enable/ack, observes the timer.
  modport master (
    output iStart, iLoadVal, iEnable, iAck,
    input  oCount, oBusy, oDone, oTc
  );

  // Timer side.
  modport slave (
    input  iStart, iLoadVal, iEnable, iAck,
    output oCount, oBusy, oDone, oTc
  );
endinterface

// File: rtl/count_down_timer.sv
// count_down_timer: loadable, enable-gated down-counter with terminal-count
// pulse and a done flag held until acknowledged.
// Optional periodic mode: define COUNT_DOWN_TIMER_AUTO_RELOAD_EN to reload
// from the captured period instead of stopping at zero.
module count_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic               iClock,
  input  logic               iReset,
  count_down_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] period_q, period_d;
  logic             sticky_q, sticky_d;
  logic             reload_evt;
`endif

  // State and datapath registers, cleared asynchronously by iReset.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q  <= IDLE;
      count_q  <= ZERO;
      tc_q     <= 1'b0;
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
      period_q <= ZERO;
      sticky_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q  <= state_d;
      count_q  <= count_d;
      tc_q     <= tc_d;
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
      period_q <= period_d;
      sticky_q <= sticky_d;
`endif
    end
  end

  // Next-state and next-count decode; iStart overrides everything else.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
    period_d   = period_q;
    sticky_d   = sticky_q;
    reload_evt = 1'b0;
`endif

    if (bus.iStart) begin
      // Accepted in every state; an abandoned count produces no pulse.
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
      period_d = bus.iLoadVal;
`endif
      if (bus.iLoadVal == ZERO) begin
        count_d = ZERO;
        tc_d    = 1'b1;
        state_d = DONE;
      end else begin
        count_d = bus.iLoadVal;
        state_d = RUN;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          if (bus.iEnable) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else begin
              // Terminal step; a zero count here is treated the same so the
              // counter can never wrap below zero.
              tc_d = 1'b1;
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
              count_d    = period_q;
              reload_evt = 1'b1;
`else
              count_d = ZERO;
              state_d = DONE;
`endif
            end
          end
        end
        DONE: begin
          count_d = ZERO;
          if (bus.iAck) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = ZERO;
        end
      endcase
    end

`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
    // A fresh reload event wins over a simultaneous acknowledge.
    if (reload_evt) begin
      sticky_d = 1'b1;
    end else if (bus.iAck) begin
      sticky_d = 1'b0;
    end
`endif
  end

  assign bus.oCount = count_q;
  assign bus.oBusy  = (state_q == RUN);
  assign bus.oTc    = tc_q;
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
  assign bus.oDone  = (state_q == DONE) || sticky_q;
`else
  assign bus.oDone  = (state_q == DONE);
`endif

  // Structural invariants of the counter.
  a_done_holds_zero : assert property (@(posedge iClock) disable iff (!iReset)
    (state_q == DONE) |-> (count_q == ZERO));
  a_run_nonzero : assert property (@(posedge iClock) disable iff (!iReset)
    (state_q == RUN) |-> (count_q != ZERO));
`ifndef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
  a_tc_at_zero : assert property (@(posedge iClock) disable iff (!iReset)
    tc_q |-> (count_q == ZERO));
`endif

endmodule

// File: tb/tb_count_down_timer.sv
// Self-checking bench for count_down_timer: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_count_down_timer;

  localparam int WIDTH = 8;

  logic iClock = 1'b0;
  logic iReset = 1'b0;
  logic chk_en = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  count_down_timer_if #(.WIDTH(WIDTH)) bus ();

  count_down_timer #(.WIDTH(WIDTH)) dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus.slave)
  );

  always #5 iClock = ~iClock;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural model: what the timer must show after each clock edge.
  int m_count  = 0;
  int m_period = 0;
  bit m_running  = 0;
  bit m_finished = 0;
  bit m_flag     = 0;
  bit m_tc       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      m_count = 0; m_period = 0; m_running = 0;
      m_finished = 0; m_flag = 0; m_tc = 0;
    end else begin
      bit reloaded;
      reloaded = 0;
      m_tc = 0;
      if (bus.iStart) begin
        m_period = int'(bus.iLoadVal);
        m_count  = int'(bus.iLoadVal);
        m_running  = (m_count != 0);
        m_finished = (m_count == 0);
        m_tc       = (m_count == 0);
      end else if (m_running && bus.iEnable) begin
        if (m_count > 1) begin
          m_count = m_count - 1;
        end else begin
          m_tc = 1;
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
          m_count  = m_period;
          reloaded = 1;
`else
          m_count = 0;
          m_running = 0;
          m_finished = 1;
`endif
        end
      end else if (m_finished && bus.iAck) begin
        m_finished = 0;
      end
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
      if (reloaded) m_flag = 1;
      else if (bus.iAck) m_flag = 0;
`endif
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge iClock) begin
    if (chk_en) begin
      check("model_count", bus.oCount, m_count);
      check("model_busy",  bus.oBusy,  m_running);
      check("model_done",  bus.oDone,  m_finished || m_flag);
      check("model_tc",    bus.oTc,    m_tc);
    end
  end

  // Apply one cycle of inputs and return just after the consuming edge.
  task automatic cyc(input bit s, input int ld, input bit en, input bit ak);
    @(negedge iClock);
    bus.iStart   = s;
    bus.iLoadVal = ld[WIDTH-1:0];
    bus.iEnable  = en;
    bus.iAck     = ak;
    @(posedge iClock);
    #1;
  endtask

  task automatic expect_out(input string name, input int c, input bit b, input bit d, input bit t);
    check({name, "_count"}, bus.oCount, c);
    check({name, "_busy"},  bus.oBusy,  b);
    check({name, "_done"},  bus.oDone,  d);
    check({name, "_tc"},    bus.oTc,    t);
  endtask

  // Assert reset between edges and confirm the outputs clear with no edge.
  task automatic async_reset(input string name);
    @(posedge iClock);
    #3;
    iReset = 1'b0;
    #1;
    expect_out(name, 0, 0, 0, 0);
    @(negedge iClock);
    #1;
    iReset = 1'b1;
  endtask

  initial begin
    int n;
    bus.iStart = 0; bus.iLoadVal = '0; bus.iEnable = 0; bus.iAck = 0;
    repeat (3) @(posedge iClock);
    chk_en = 1'b1;
    expect_out("reset", 0, 0, 0, 0);
    @(negedge iClock);
    iReset = 1'b1;
    cyc(0, 0, 1, 1);
    expect_out("idle_ignores", 0, 0, 0, 0);

`ifndef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
    // One-shot load of 5.
    cyc(1, 5, 1, 0);
    expect_out("os_load", 5, 1, 0, 0);
    for (int i = 4; i >= 1; i--) begin
      cyc(0, 0, 1, 1);
      expect_out("os_dec", i, 1, 0, 0);
    end
    cyc(0, 0, 1, 0);
    expect_out("os_zero", 0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    expect_out("os_hold", 0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    expect_out("os_ack", 0, 0, 0, 0);

    // Pause: enable pattern 1,0,0,1,1,1 from a load of 4.
    cyc(1, 4, 0, 0);
    expect_out("pz_load", 4, 1, 0, 0);
    begin
      bit en_pat [6]  = '{1, 0, 0, 1, 1, 1};
      int cnt_pat [6] = '{3, 3, 3, 2, 1, 0};
      for (int i = 0; i < 6; i++) begin
        cyc(0, 0, en_pat[i], 0);
        expect_out("pz_step", cnt_pat[i], i < 5, i == 5, i == 5);
      end
    end
    cyc(0, 0, 0, 1);

    // Restart mid-count, then zero load from RUN.
    cyc(1, 6, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    expect_out("rs_pre", 4, 1, 0, 0);
    cyc(1, 9, 1, 0);
    expect_out("rs_reload", 9, 1, 0, 0);
    cyc(1, 0, 1, 0);
    expect_out("zl_load", 0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    expect_out("zl_after", 0, 0, 1, 0);

    // Start and ack together in DONE: reload wins.
    cyc(1, 7, 0, 1);
    expect_out("done_start_ack", 7, 1, 0, 0);

    // Full-range load of 255.
    cyc(1, 255, 1, 0);
    n = 0;
    while (!bus.oTc && n < 300) begin
      cyc(0, 0, 1, 0);
      n++;
    end
    check("max_cycles", n, 255);
    cyc(0, 0, 1, 0);
    expect_out("max_no_wrap", 0, 0, 1, 0);
    cyc(0, 0, 0, 1);
`else
    // Periodic mode: period 3 over 9 enabled cycles, ack at cycle 4.
    cyc(1, 3, 1, 0);
    expect_out("ar_load", 3, 1, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 0, 1, i == 4);
      expect_out("ar_step", (i % 3 == 0) ? 3 : 3 - (i % 3), 1,
                 (i >= 3) && (i != 4) && (i != 5), i % 3 == 0);
    end
    cyc(1, 0, 0, 0);
    expect_out("ar_zero_load", 0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    expect_out("ar_ack", 0, 0, 0, 0);
`endif

    // Asynchronous reset mid-count.
    cyc(1, 10, 1, 0);
    repeat (3) cyc(0, 0, 1, 0);
    check("mid_pre_count", bus.oCount, 7);
    async_reset("mid_reset");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int ld;
      case ($urandom_range(0, 3))
        0: ld = 0;
        1: ld = int'($urandom_range(1, 3));
        2: ld = int'($urandom_range(1, 12));
        default: ld = int'($urandom_range(0, 255));
      endcase
      cyc($urandom_range(0, 15) == 0, ld, $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) == 0);
      if (i % 700 == 699) async_reset("rand_reset");
    end

    @(negedge iClock);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
